imem_load_arbiter: RTL

//  Owns the single write port of the instruction memory. Merges ALU-side instruction writes (already address-decoded)

---
 rtl/imem_load_arbiter_pkg.sv | 16 +
 rtl/imem_load_arbiter_quiesce_timer.sv | 32 +++
 rtl/imem_load_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-memory write-port arbiter.
package imem_load_arbiter_pkg;

  // Session state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    LOAD    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Collision counter width and its saturation value
  localparam int COLL_WIDTH = 16;
  localparam logic [COLL_WIDTH-1:0] COLL_MAX = {COLL_WIDTH{1'b1}};

endpackage

// File: rtl/imem_load_arbiter_quiesce_timer.sv
// Loadable down-counter used to hold thread issue for a fixed number of cycles
// before the first load write. expired is high when the count is zero, or is
// reaching zero on this cycle's decrement, so the caller can leave its waiting
// state on exactly the last counted cycle.
module imem_load_arbiter_quiesce_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority over decrement; the counter parks at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (decrement && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expired = (count_reg == '0) ||
                   (decrement && (count_reg == WIDTH'(1)));

endmodule

// File: rtl/imem_load_arbiter.sv
// Owner of the instruction-memory write port: merges decoded ALU writes with a
// streamed program-load session. The ALU always wins the port; a load word
// that loses simply stays pending at the loader until the next free cycle.
module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int I_WORD_WIDTH   = 36,
  parameter int I_ADDR_WIDTH   = 10,
  parameter int I_DEPTH        = 1024,
  parameter int QUIESCE_CYCLES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [I_ADDR_WIDTH-1:0] load_base,
  input  logic [I_ADDR_WIDTH:0]   load_count,
  input  logic                    load_valid,
  input  logic [I_WORD_WIDTH-1:0] load_data,
  output logic                    load_ready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    thread_hold,
  input  logic                    alu_wren,
  input  logic [I_ADDR_WIDTH-1:0] alu_write_addr,
  input  logic [I_WORD_WIDTH-1:0] alu_write_data,
  output logic                    I_wren,
  output logic [I_ADDR_WIDTH-1:0] I_write_addr,
  output logic [I_WORD_WIDTH-1:0] I_write_data,
  output logic [COLL_WIDTH-1:0]   collisions
);

  localparam int TIMER_WIDTH = $clog2(QUIESCE_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0]  QUIESCE_LOAD = TIMER_WIDTH'(QUIESCE_CYCLES);
  localparam logic [I_ADDR_WIDTH-1:0] LAST_ADDR    = I_ADDR_WIDTH'(I_DEPTH - 1);

  state_t                  state_reg;
  logic [I_ADDR_WIDTH-1:0] addr_ptr_reg;
  logic [I_ADDR_WIDTH:0]   remaining_reg;
  logic                    timer_load;
  logic                    timer_expired;
  logic                    remaining_nonzero;
  logic                    transfer;

  assign remaining_nonzero = (remaining_reg != '0);
  assign timer_load        = (state_reg == IDLE) && load_start && (load_count != '0);

  imem_load_arbiter_quiesce_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_quiesce_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (QUIESCE_LOAD),
    .decrement  (state_reg == QUIESCE),
    .expired    (timer_expired)
  );

  // Status outputs are decoded straight from the state register
  always_comb begin
    load_busy   = (state_reg == QUIESCE) || (state_reg == LOAD);
    thread_hold = (state_reg == QUIESCE) || (state_reg == LOAD);
    load_done   = (state_reg == DONE);
    load_ready  = (state_reg == LOAD) && !alu_wren && remaining_nonzero;
    transfer    = load_valid && load_ready;
  end

  // Session FSM, address/remaining counters, write-port registers, collision count
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_ptr_reg  <= '0;
      remaining_reg <= '0;
      I_wren        <= 1'b0;
      I_write_addr  <= '0;
      I_write_data  <= '0;
      collisions    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            if (load_count != '0) begin
              state_reg     <= QUIESCE;
              addr_ptr_reg  <= load_base;
              remaining_reg <= load_count;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        QUIESCE: begin
          if (timer_expired) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (transfer) begin
            addr_ptr_reg  <= (addr_ptr_reg == LAST_ADDR) ? '0 : addr_ptr_reg + I_ADDR_WIDTH'(1);
            remaining_reg <= remaining_reg - (I_ADDR_WIDTH + 1)'(1);
            if (remaining_reg == (I_ADDR_WIDTH + 1)'(1)) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // ALU owns the port whenever it writes; address/data hold otherwise
      I_wren <= alu_wren || transfer;
      if (alu_wren) begin
        I_write_addr <= alu_write_addr;
        I_write_data <= alu_write_data;
      end else if (transfer) begin
        I_write_addr <= addr_ptr_reg;
        I_write_data <= load_data;
      end

      if ((state_reg == LOAD) && alu_wren && load_valid && remaining_nonzero &&
          (collisions != COLL_MAX)) begin
        collisions <= collisions + COLL_WIDTH'(1);
      end
    end
  end

endmodule
